// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: owns PCF, drives the read-first instruction memory, and builds the IF/ID side-band.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_pc_unit #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     StallF,
  input  logic                     RedirectE,
  input  logic [31:0]              RedirectPC,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  output logic                     imem_en_,
  output logic                     imem_clr,
  output logic [31:0]              PCF,
  output logic [31:0]              PCPlus4D,
  output logic                     ValidD,
  output logic                     AlignErr,
  output logic [31:0]              FetchCnt,
  output logic [31:0]              StallCnt,
  output logic [31:0]              FlushCnt
);

  typedef enum logic [0:0] {StReset, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pcplus4d_q, pcplus4d_d;
  logic        validd_q, validd_d;
  logic        alignerr_q, alignerr_d;
  logic [31:0] pc_inc;
  logic        do_fetch, do_stall, do_flush;

  assign pc_inc = pcf_q + 32'd4;

  // Redirect outranks stall; the reset bubble does neither.
  always_comb begin
    do_fetch = 1'b0;
    do_stall = 1'b0;
    do_flush = 1'b0;
    if (state_q == StRun) begin
      if (RedirectE)   do_flush = 1'b1;
      else if (StallF) do_stall = 1'b1;
      else             do_fetch = 1'b1;
    end
  end

  always_comb begin
    imem_en_ = 1'b0;
    imem_clr = 1'b0;
    if (!rst_ || state_q == StReset || do_flush) begin
      imem_clr = 1'b1;
    end else if (do_stall) begin
      imem_en_ = 1'b1;
    end
  end

  always_comb begin
    state_d    = StRun;
    pcf_d      = pcf_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;
    alignerr_d = alignerr_q;
    if (state_q == StReset) begin
      validd_d = 1'b0;
    end else if (do_flush) begin
      pcf_d    = RedirectPC & ~32'h3;
      validd_d = 1'b0;
      if (RedirectPC[1:0] != 2'b00) alignerr_d = 1'b1;
    end else if (do_fetch) begin
      pcf_d      = pc_inc;
      pcplus4d_d = pc_inc;
      validd_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= StReset;
      pcf_q      <= RESET_PC;
      pcplus4d_q <= 32'd0;
      validd_q   <= 1'b0;
      alignerr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
      alignerr_q <= alignerr_d;
    end
  end

  assign imem_addr = pcf_q[ADDRESS_WIDTH+1:2];
  assign PCF       = pcf_q;
  assign PCPlus4D  = pcplus4d_q;
  assign ValidD    = validd_q;
  assign AlignErr  = alignerr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (do_fetch) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (do_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (do_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign FetchCnt = fetch_cnt_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign FetchCnt = 32'd0;
  assign StallCnt = 32'd0;
  assign FlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, sequential fetch, stall, redirect, alignment, wrap, counters.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_;
  logic        StallF;
  logic        RedirectE;
  logic [31:0] RedirectPC;

  logic [7:0]  addr0, addr1, addr2;
  logic        en0, en1, en2, clr0, clr1, clr2;
  logic [31:0] pcf0, pcf1, pcf2, p4d0, p4d1, p4d2;
  logic        vd0, vd1, vd2, ae0, ae1, ae2;
  logic [31:0] fc0, sc0, xc0, fc1, sc1, xc1, fc2, sc2, xc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.ADDRESS_WIDTH(8), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_(rst_), .StallF(StallF), .RedirectE(RedirectE), .RedirectPC(RedirectPC),
    .imem_addr(addr0), .imem_en_(en0), .imem_clr(clr0), .PCF(pcf0), .PCPlus4D(p4d0),
    .ValidD(vd0), .AlignErr(ae0), .FetchCnt(fc0), .StallCnt(sc0), .FlushCnt(xc0)
  );

  fetch_pc_unit #(.ADDRESS_WIDTH(8), .RESET_PC(32'h0000_03FC)) dut_wa (
    .clk(clk), .rst_(rst_), .StallF(StallF), .RedirectE(RedirectE), .RedirectPC(RedirectPC),
    .imem_addr(addr1), .imem_en_(en1), .imem_clr(clr1), .PCF(pcf1), .PCPlus4D(p4d1),
    .ValidD(vd1), .AlignErr(ae1), .FetchCnt(fc1), .StallCnt(sc1), .FlushCnt(xc1)
  );

  fetch_pc_unit #(.ADDRESS_WIDTH(8), .RESET_PC(32'hFFFF_FFFC)) dut_wp (
    .clk(clk), .rst_(rst_), .StallF(StallF), .RedirectE(RedirectE), .RedirectPC(RedirectPC),
    .imem_addr(addr2), .imem_en_(en2), .imem_clr(clr2), .PCF(pcf2), .PCPlus4D(p4d2),
    .ValidD(vd2), .AlignErr(ae2), .FetchCnt(fc2), .StallCnt(sc2), .FlushCnt(xc2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] p4,
                          input logic vd);
    check({tag, ".PCF"}, pcf0, pc);
    check({tag, ".PCPlus4D"}, p4d0, p4);
    check({tag, ".ValidD"}, {31'd0, vd0}, {31'd0, vd});
  endtask

  task automatic chk_mem(input string tag, input logic [7:0] a, input logic en_, input logic clr);
    check({tag, ".imem_addr"}, {24'd0, addr0}, {24'd0, a});
    check({tag, ".imem_en_"}, {31'd0, en0}, {31'd0, en_});
    check({tag, ".imem_clr"}, {31'd0, clr0}, {31'd0, clr});
  endtask

  initial begin
    rst_ = 1'b0; StallF = 1'b0; RedirectE = 1'b0; RedirectPC = 32'd0;
    #1;
    chk_mem("rst_comb", 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ifid("rst", 32'h0, 32'h0, 1'b0);
      chk_mem("rst_mem", 8'h00, 1'b0, 1'b1);
      check("rst.AlignErr", {31'd0, ae0}, 32'd0);
      check("rst.wa_PCF", pcf1, 32'h0000_03FC);
    end

    // Release: one S_RESET bubble cycle.
    rst_ = 1'b1;
    #1;
    chk_mem("sreset", 8'h00, 1'b0, 1'b1);
    tick();                                          // edge 1
    chk_ifid("e1", 32'h0, 32'h0, 1'b0);
    chk_mem("e1_mem", 8'h00, 1'b0, 1'b0);
    check("e1.wa_addr", {24'd0, addr1}, 32'h0000_00FF);
    tick();                                          // edge 2
    chk_ifid("e2", 32'h4, 32'h4, 1'b1);
    check("e2.addr", {24'd0, addr0}, 32'd1);
    check("e2.wa_PCF", pcf1, 32'h0000_0400);
    check("e2.wa_addr", {24'd0, addr1}, 32'd0);
    check("e2.wp_PCF", pcf2, 32'd0);
    check("e2.wp_PCPlus4D", p4d2, 32'd0);
    tick();                                          // edge 3
    chk_ifid("e3", 32'h8, 32'h8, 1'b1);
    check("e3.addr", {24'd0, addr0}, 32'd2);
    tick(); tick();                                  // edges 4,5
    chk_ifid("e5", 32'h10, 32'h10, 1'b1);

    StallF = 1'b1;
    #1;
    chk_mem("stall_mem", 8'h04, 1'b1, 1'b0);
    tick(); tick();                                  // edges 6,7
    chk_ifid("stall", 32'h10, 32'h10, 1'b1);
    StallF = 1'b0;
    tick();                                          // edge 8
    chk_ifid("unstall", 32'h14, 32'h14, 1'b1);
    tick(); tick(); tick();                          // edges 9-11
    chk_ifid("e11", 32'h20, 32'h20, 1'b1);

    RedirectE = 1'b1; RedirectPC = 32'h40;
    #1;
    chk_mem("redir_mem", 8'h08, 1'b0, 1'b1);
    tick();                                          // edge 12
    RedirectE = 1'b0;
    chk_ifid("redir", 32'h40, 32'h20, 1'b0);
    tick();                                          // edge 13
    chk_ifid("redir_tgt", 32'h44, 32'h44, 1'b1);

    StallF = 1'b1; RedirectE = 1'b1; RedirectPC = 32'h80;
    #1;
    chk_mem("both_mem", 8'h11, 1'b0, 1'b1);
    tick();                                          // edge 14
    chk_ifid("both", 32'h80, 32'h44, 1'b0);
    check("both.AlignErr", {31'd0, ae0}, 32'd0);

    StallF = 1'b0; RedirectPC = 32'h43;
    tick();                                          // edge 15
    RedirectE = 1'b0;
    chk_ifid("misal", 32'h40, 32'h44, 1'b0);
    check("misal.AlignErr", {31'd0, ae0}, 32'd1);
    tick();                                          // edge 16
    chk_ifid("post_misal", 32'h44, 32'h44, 1'b1);
    check("sticky.AlignErr", {31'd0, ae0}, 32'd1);

`ifdef FETCH_PERF_CNT_EN
    check("FetchCnt", fc0, 32'd10);
    check("StallCnt", sc0, 32'd2);
    check("FlushCnt", xc0, 32'd3);
`else
    check("FetchCnt", fc0, 32'd0);
    check("StallCnt", sc0, 32'd0);
    check("FlushCnt", xc0, 32'd0);
`endif

    // Reset dominates a concurrent stall and redirect.
    StallF = 1'b1; RedirectE = 1'b1; RedirectPC = 32'h100; rst_ = 1'b0;
    #1;
    chk_mem("rst2_comb", 8'h11, 1'b0, 1'b1);
    tick();                                          // edge 17
    chk_ifid("rst2", 32'h0, 32'h0, 1'b0);
    check("rst2.AlignErr", {31'd0, ae0}, 32'd0);
    check("rst2.FetchCnt", fc0, 32'd0);
    check("rst2.FlushCnt", xc0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end for the 5-stage DLX/MIPS pipeline. It owns the program counter and drives the synchronous, read-first instruction memory: address, active-low enable and clear. It selects the next PC: sequential, redirected by a resolved branch or jump, or held on stall. It also produces the PC+4 and valid bits that sit beside InstrD in the IF/ID boundary.

## Interface
- ADDRESS_WIDTH, 8, word-address width of instruction memory; word index is PC[ADDRESS_WIDTH+1:2].
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.
- clk  in  1  clock, all state updates on rising edge.
- rst_  in  1  reset, synchronous, active-low.
- StallF  in  1  hold fetch; PC and IF/ID-side registers frozen.
- RedirectE  in  1  taken branch/jump resolved downstream; load RedirectPC, squash wrong-path fetch.
- RedirectPC  in  32  byte target address.
- imem_addr  out  ADDRESS_WIDTH  = PCF[ADDRESS_WIDTH+1:2].
- imem_en_  out  1  memory enable, active-low.
- imem_clr  out  1  memory output clear (InstrD <= 0 when enabled).
- PCF  out  32  PC of the word currently being fetched.
- PCPlus4D  out  32  PC+4 of the word presented on InstrD.
- ValidD  out  1  InstrD holds a real (non-bubble) instruction.
- AlignErr  out  1  sticky: a misaligned RedirectPC was received.
- FetchCnt, StallCnt, FlushCnt  out  32 each  performance counters (see Configuration).

## Operation
- FSM states: S_RESET, S_RUN.
- rst_=0 at an edge: PCF<=RESET_PC, state<=S_RESET, PCPlus4D<=0, ValidD<=0, AlignErr<=0, counters<=0.
- While rst_=0, combinationally: imem_en_=0, imem_clr=1, so memory output also clears.
- S_RESET (one cycle after rst_ rises): imem_en_=0, imem_clr=1, PC not advanced, ValidD<=0; next state S_RUN.
- S_RUN, priority RedirectE > StallF > sequential:
  - Redirect: imem_en_=0, imem_clr=1; PCF<=RedirectPC & ~32'h3; ValidD<=0; PCPlus4D unchanged. If RedirectPC[1:0]!=0, AlignErr<=1.
  - Stall (no redirect): imem_en_=1, imem_clr=0; PCF, PCPlus4D and ValidD hold. The memory holds InstrD.
  - Sequential: imem_en_=0, imem_clr=0; PCF<=PCF+4, PCPlus4D<=PCF+4, ValidD<=1.
- Redirect and stall together: redirect wins. The stalled decode-stage word is wrong-path and is flushed.
- Arithmetic: PC+4 is modulo 2^32. imem_addr wraps modulo 2^ADDRESS_WIDTH words, with no error.
- AlignErr is cleared only by reset.

## Timing
- Fetch latency: 1 cycle. The word addressed while PCF=p appears on InstrD after the next edge, with PCPlus4D=p+4 and ValidD=1 on the same edge.
- imem_addr, imem_en_ and imem_clr are combinational from PCF, state, rst_, StallF and RedirectE. No other outputs are combinational.
- After rst_ release, the first valid InstrD (RESET_PC) appears 2 edges later: one S_RESET bubble, then the fetch.
- Redirect penalty: 1 bubble (ValidD=0) in the IF/ID slot. The target word is valid one edge after that.
- Reset mid-stall or mid-redirect: reset dominates all inputs.

## Configuration
- FETCH_PERF_CNT_EN defined: counters are present. In S_RUN:
  - FetchCnt increments on each sequential fetch.
  - StallCnt increments on each stall cycle.
  - FlushCnt increments on each redirect.
  - All three wrap at 2^32 and reset to 0.
- Not defined: FetchCnt, StallCnt and FlushCnt are tied to 0 and no counter logic is synthesised. Ports remain, so the interface is unchanged.

## Test plan
- Reset, RESET_PC=0: rst_ low 3 cycles -> imem_en_=0, imem_clr=1, PCF=0, ValidD=0. After release: one bubble, then imem_addr 0,1,2,… and PCPlus4D 4,8,12 with ValidD=1.
- Stall: StallF=1 for 2 cycles at PCF=0x10 -> imem_en_=1, PCF stays 0x10, PCPlus4D/ValidD held. On release, PCF=0x14 after the next edge.
- Redirect: RedirectE=1, RedirectPC=0x40 at PCF=0x20 -> imem_clr=1, then ValidD=0 and PCF=0x40. Next edge: PCPlus4D=0x44, ValidD=1.
- Simultaneous StallF=1 and RedirectE=1 to 0x80 -> imem_en_=0, imem_clr=1, PCF=0x80. Redirect with RedirectPC=0x43 -> PCF=0x40, AlignErr=1 and it stays 1 until rst_=0.
- Wrap: RESET_PC=0x3FC -> imem_addr 0xFF then 0x00 while PCF=0x400. RESET_PC=0xFFFF_FFFC -> PCF wraps to 0.
- With FETCH_PERF_CNT_EN: 5 fetches, 2 stalls, 1 redirect -> FetchCnt=5, StallCnt=2, FlushCnt=1. Without the macro, all counters read 0.
